// File: rtl/vx_itr_jal_ovl_ctl.sv
// Interrupt-controller side of the execute_hw_itr interface: owns JALOL and RHA,
// captures reported return PCs, counts warp hits and serves a registered CSR read port.
module vx_itr_jal_ovl_ctl #(
    parameter int unsigned WARP_CNT = 4,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_W    = $clog2(WARP_CNT) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rha_wr_valid,
    input  logic [XLEN-1:0] rha_wr_data,
    input  logic            arm_req,
    input  logic            abort_req,
    input  logic            commit_ret_pc,
    input  logic [XLEN-1:0] ret_pc,
    input  logic            commit_ret_pc_w0,
    input  logic [XLEN-1:0] ret_pc_w0,
    input  logic            all_hit,
    output logic            overload_jal,
    output logic [XLEN-1:0] ret_handler_addr,
    output logic            itr_done,
    input  logic [1:0]      csr_rd_addr,
    output logic [XLEN-1:0] csr_rd_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W:0] HIT_MAX = WARP_CNT[CNT_W:0];

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  rha_q, rha_d;
    logic             rha_valid_q, rha_valid_d;
    logic [XLEN-1:0]  rav_q, rav_d;
    logic [XLEN-1:0]  ravw0_q, ravw0_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             arm_err_q, arm_err_d;
    logic             wr_err_q, wr_err_d;
    logic             spur_err_q, spur_err_d;
    logic             ovf_err_q, ovf_err_d;
    logic             ovl_q, ovl_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  csr_q, csr_d;
    logic [CNT_W:0]   hit_sum;
    logic [XLEN-1:0]  status;

    always_comb begin
        state_d     = state_q;
        rha_d       = rha_q;
        rha_valid_d = rha_valid_q;
        rav_d       = rav_q;
        ravw0_d     = ravw0_q;
        hit_cnt_d   = hit_cnt_q;
        arm_err_d   = arm_err_q;
        wr_err_d    = wr_err_q;
        spur_err_d  = spur_err_q;
        ovf_err_d   = ovf_err_q;
        hit_sum     = {1'b0, hit_cnt_q} + {{CNT_W{1'b0}}, commit_ret_pc}
                                        + {{CNT_W{1'b0}}, commit_ret_pc_w0};

        case (state_q)
            ST_IDLE: begin
                if (arm_req && !abort_req) begin
                    if (rha_valid_q) begin
                        state_d    = ST_ARMED;
                        hit_cnt_d  = '0;
                        arm_err_d  = 1'b0;
                        wr_err_d   = 1'b0;
                        spur_err_d = 1'b0;
                        ovf_err_d  = 1'b0;
                    end else begin
                        arm_err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                // Strobes coincident with all_hit are still captured and counted.
                if (commit_ret_pc)    rav_d   = ret_pc;
                if (commit_ret_pc_w0) ravw0_d = ret_pc_w0;
                if (hit_sum > HIT_MAX) begin
                    hit_cnt_d = HIT_MAX[CNT_W-1:0];
                    ovf_err_d = 1'b1;
                end else begin
                    hit_cnt_d = hit_sum[CNT_W-1:0];
                end
                if (all_hit) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (abort_req) state_d = ST_IDLE;

        if (state_q != ST_ARMED && (commit_ret_pc || commit_ret_pc_w0))
            spur_err_d = 1'b1;

        if (rha_wr_valid) begin
            if (state_q == ST_ARMED) begin
                wr_err_d = 1'b1;
            end else begin
                rha_d       = rha_wr_data;
                rha_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        status               = '0;
        status[1:0]          = state_q;
        status[2]            = rha_valid_q;
        status[3]            = arm_err_q;
        status[4]            = wr_err_q;
        status[5]            = spur_err_q;
        status[6]            = ovf_err_q;
        status[7 +: CNT_W]   = hit_cnt_q;
    end

    // Read mux works off current register values, so a coincident capture is not visible yet.
    always_comb begin
        csr_d = '0;
        case (csr_rd_addr)
            2'd0:    csr_d = rha_q;
            2'd1:    csr_d = rav_q;
            2'd2:    csr_d = ravw0_q;
            default: csr_d = status;
        endcase
        ovl_d  = (state_d == ST_ARMED);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rha_q       <= '0;
            rha_valid_q <= 1'b0;
            rav_q       <= '0;
            ravw0_q     <= '0;
            hit_cnt_q   <= '0;
            arm_err_q   <= 1'b0;
            wr_err_q    <= 1'b0;
            spur_err_q  <= 1'b0;
            ovf_err_q   <= 1'b0;
            ovl_q       <= 1'b0;
            done_q      <= 1'b0;
            csr_q       <= '0;
        end else begin
            state_q     <= state_d;
            rha_q       <= rha_d;
            rha_valid_q <= rha_valid_d;
            rav_q       <= rav_d;
            ravw0_q     <= ravw0_d;
            hit_cnt_q   <= hit_cnt_d;
            arm_err_q   <= arm_err_d;
            wr_err_q    <= wr_err_d;
            spur_err_q  <= spur_err_d;
            ovf_err_q   <= ovf_err_d;
            ovl_q       <= ovl_d;
            done_q      <= done_d;
            csr_q       <= csr_d;
        end
    end

    assign overload_jal     = ovl_q;
    assign itr_done         = done_q;
    assign ret_handler_addr = rha_q;
    assign csr_rd_data      = csr_q;

endmodule

// File: tb/tb_vx_itr_jal_ovl_ctl.sv
// Scenario-based bench for vx_itr_jal_ovl_ctl; CSR read expectations go through a queue.
module tb_vx_itr_jal_ovl_ctl;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            reset;
    logic            rha_wr_valid;
    logic [XLEN-1:0] rha_wr_data;
    logic            arm_req;
    logic            abort_req;
    logic            commit_ret_pc;
    logic [XLEN-1:0] ret_pc;
    logic            commit_ret_pc_w0;
    logic [XLEN-1:0] ret_pc_w0;
    logic            all_hit;
    logic            overload_jal;
    logic [XLEN-1:0] ret_handler_addr;
    logic            itr_done;
    logic [1:0]      csr_rd_addr;
    logic [XLEN-1:0] csr_rd_data;

    int unsigned n_pass;
    int unsigned n_total;
    int unsigned done_pulses;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] e;

    vx_itr_jal_ovl_ctl #(.WARP_CNT(4), .XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .rha_wr_valid     (rha_wr_valid),
        .rha_wr_data      (rha_wr_data),
        .arm_req          (arm_req),
        .abort_req        (abort_req),
        .commit_ret_pc    (commit_ret_pc),
        .ret_pc           (ret_pc),
        .commit_ret_pc_w0 (commit_ret_pc_w0),
        .ret_pc_w0        (ret_pc_w0),
        .all_hit          (all_hit),
        .overload_jal     (overload_jal),
        .ret_handler_addr (ret_handler_addr),
        .itr_done         (itr_done),
        .csr_rd_addr      (csr_rd_addr),
        .csr_rd_data      (csr_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (itr_done === 1'b1) done_pulses++;

    function automatic logic [XLEN-1:0] st(input int hit, input bit ovf, input bit spur,
                                           input bit wr, input bit arm, input bit rv,
                                           input int s);
        logic [XLEN-1:0] r;
        r      = '0;
        r[1:0] = s[1:0];
        r[2]   = rv;
        r[3]   = arm;
        r[4]   = wr;
        r[5]   = spur;
        r[6]   = ovf;
        r[9:7] = hit[2:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_issue(input logic [1:0] a, input logic [XLEN-1:0] ex);
        csr_rd_addr = a;
        exp_q.push_back(ex);
        tick();
    endtask

    task automatic write_rha(input logic [XLEN-1:0] d);
        rha_wr_valid = 1'b1;
        rha_wr_data  = d;
        tick();
        rha_wr_valid = 1'b0;
    endtask

    task automatic arm();
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_total++; if (overload_jal !== 1'b0) $display("FAIL reset_ovl: got %b exp 0", overload_jal); else n_pass++;
        n_total++; if (itr_done !== 1'b0) $display("FAIL reset_done: got %b exp 0", itr_done); else n_pass++;
        n_total++; if (ret_handler_addr !== '0) $display("FAIL reset_rha: got %h exp 0", ret_handler_addr); else n_pass++;
        n_total++; if (csr_rd_data !== '0) $display("FAIL reset_csr: got %h exp 0", csr_rd_data); else n_pass++;
        reset = 1'b0;
        tick();
        csr_issue(2'd3, st(0, 0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL reset_status: got %h exp %h", csr_rd_data, e); else n_pass++;
    endtask

    task automatic test_basic_sequence();
        logic [XLEN-1:0] pcs[3];
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
        done_pulses = 0;
        write_rha(32'h8000_0100);
        n_total++; if (ret_handler_addr !== 32'h8000_0100) $display("FAIL basic_rha_out: got %h exp 80000100", ret_handler_addr); else n_pass++;
        n_total++; if (overload_jal !== 1'b0) $display("FAIL basic_ovl_idle: got %b exp 0", overload_jal); else n_pass++;
        arm();
        n_total++; if (overload_jal !== 1'b1) $display("FAIL basic_ovl_armed: got %b exp 1", overload_jal); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            commit_ret_pc = 1'b1;
            ret_pc        = pcs[i];
            tick();
            n_total++; if (overload_jal !== 1'b1) $display("FAIL basic_ovl_hit%0d: got %b exp 1", i, overload_jal); else n_pass++;
        end
        commit_ret_pc    = 1'b0;
        commit_ret_pc_w0 = 1'b1;
        ret_pc_w0        = 32'h400;
        tick();
        commit_ret_pc_w0 = 1'b0;
        all_hit = 1'b1;
        tick();
        all_hit = 1'b0;
        n_total++; if (itr_done !== 1'b1) $display("FAIL basic_done_pulse: got %b exp 1", itr_done); else n_pass++;
        n_total++; if (overload_jal !== 1'b0) $display("FAIL basic_ovl_done: got %b exp 0", overload_jal); else n_pass++;
        tick();
        n_total++; if (itr_done !== 1'b0) $display("FAIL basic_done_end: got %b exp 0", itr_done); else n_pass++;
        csr_issue(2'd0, 32'h8000_0100);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL basic_csr_rha: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd1, 32'h300);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL basic_csr_rav: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd2, 32'h400);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL basic_csr_ravw0: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd3, st(4, 0, 0, 0, 0, 1, 0));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL basic_csr_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        n_total++; if (done_pulses != 1) $display("FAIL basic_done_count: got %0d exp 1", done_pulses); else n_pass++;
    endtask

    task automatic test_arm_no_rha();
        apply_reset();
        arm();
        n_total++; if (overload_jal !== 1'b0) $display("FAIL norha_ovl: got %b exp 0", overload_jal); else n_pass++;
        csr_issue(2'd3, st(0, 0, 0, 0, 1, 0, 0));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL norha_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        n_total++; if (overload_jal !== 1'b0) $display("FAIL norha_ovl_late: got %b exp 0", overload_jal); else n_pass++;
    endtask

    task automatic test_hit_with_all_hit();
        write_rha(32'h1000);
        arm();
        commit_ret_pc = 1'b1;
        ret_pc        = 32'hA0;
        tick();
        commit_ret_pc    = 1'b1;
        ret_pc           = 32'hB0;
        commit_ret_pc_w0 = 1'b1;
        ret_pc_w0        = 32'hC0;
        all_hit          = 1'b1;
        tick();
        commit_ret_pc    = 1'b0;
        commit_ret_pc_w0 = 1'b0;
        all_hit          = 1'b0;
        n_total++; if (itr_done !== 1'b1) $display("FAIL coinc_done: got %b exp 1", itr_done); else n_pass++;
        csr_issue(2'd3, st(3, 0, 0, 0, 0, 1, 2));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL coinc_status_done: got %h exp %h", csr_rd_data, e); else n_pass++;
        n_total++; if (itr_done !== 1'b0) $display("FAIL coinc_done_end: got %b exp 0", itr_done); else n_pass++;
        csr_issue(2'd1, 32'hB0);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL coinc_rav: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd2, 32'hC0);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL coinc_ravw0: got %h exp %h", csr_rd_data, e); else n_pass++;
    endtask

    task automatic test_spurious();
        commit_ret_pc = 1'b1;
        ret_pc        = 32'hDEAD;
        tick();
        commit_ret_pc = 1'b0;
        csr_issue(2'd1, 32'hB0);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL spur_rav: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd3, st(3, 0, 1, 0, 0, 1, 0));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL spur_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        arm();
        csr_issue(2'd3, st(0, 0, 0, 0, 0, 1, 1));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL spur_cleared: got %h exp %h", csr_rd_data, e); else n_pass++;
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
    endtask

    task automatic test_abort_and_reset();
        done_pulses = 0;
        arm();
        commit_ret_pc = 1'b1;
        ret_pc        = 32'h11;
        tick();
        commit_ret_pc    = 1'b0;
        commit_ret_pc_w0 = 1'b1;
        ret_pc_w0        = 32'h22;
        tick();
        commit_ret_pc_w0 = 1'b0;
        abort_req = 1'b1;
        all_hit   = 1'b1;
        tick();
        abort_req = 1'b0;
        all_hit   = 1'b0;
        n_total++; if (overload_jal !== 1'b0) $display("FAIL abort_ovl: got %b exp 0", overload_jal); else n_pass++;
        tick();
        n_total++; if (done_pulses != 0) $display("FAIL abort_no_done: got %0d exp 0", done_pulses); else n_pass++;
        csr_issue(2'd3, st(2, 0, 0, 0, 0, 1, 0));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL abort_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd1, 32'h11);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL abort_rav: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd2, 32'h22);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL abort_ravw0: got %h exp %h", csr_rd_data, e); else n_pass++;
        arm();
        n_total++; if (overload_jal !== 1'b1) $display("FAIL rst_pre_ovl: got %b exp 1", overload_jal); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (overload_jal !== 1'b0) $display("FAIL rst_async_ovl: got %b exp 0", overload_jal); else n_pass++;
        n_total++; if (ret_handler_addr !== '0) $display("FAIL rst_async_rha: got %h exp 0", ret_handler_addr); else n_pass++;
        n_total++; if (csr_rd_data !== '0) $display("FAIL rst_async_csr: got %h exp 0", csr_rd_data); else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        csr_issue(2'd3, st(0, 0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL rst_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd1, '0);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL rst_rav: got %h exp %h", csr_rd_data, e); else n_pass++;
    endtask

    task automatic test_write_armed_and_overflow();
        write_rha(32'h2000);
        arm();
        write_rha(32'h3000);
        n_total++; if (ret_handler_addr !== 32'h2000) $display("FAIL wrarm_rha: got %h exp 00002000", ret_handler_addr); else n_pass++;
        csr_issue(2'd3, st(0, 0, 0, 1, 0, 1, 1));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL wrarm_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            commit_ret_pc = 1'b1;
            ret_pc        = 32'h500 + i;
            tick();
        end
        commit_ret_pc = 1'b0;
        csr_issue(2'd3, st(4, 1, 0, 1, 0, 1, 1));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL ovf_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        csr_issue(2'd1, 32'h504);
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL ovf_rav: got %h exp %h", csr_rd_data, e); else n_pass++;
        all_hit = 1'b1;
        tick();
        all_hit = 1'b0;
        n_total++; if (itr_done !== 1'b1) $display("FAIL ovf_done: got %b exp 1", itr_done); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        arm();
        n_total++; if (overload_jal !== 1'b1) $display("FAIL b2b_ovl: got %b exp 1", overload_jal); else n_pass++;
        commit_ret_pc    = 1'b1;
        ret_pc           = 32'h600;
        commit_ret_pc_w0 = 1'b1;
        ret_pc_w0        = 32'h700;
        tick();
        commit_ret_pc    = 1'b0;
        commit_ret_pc_w0 = 1'b0;
        csr_issue(2'd3, st(2, 0, 0, 0, 0, 1, 1));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL b2b_status: got %h exp %h", csr_rd_data, e); else n_pass++;
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        csr_issue(2'd3, st(2, 0, 0, 0, 0, 1, 1));
        e = exp_q.pop_front();
        n_total++; if (csr_rd_data !== e) $display("FAIL b2b_rearm_ignored: got %h exp %h", csr_rd_data, e); else n_pass++;
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        n_total++; if (overload_jal !== 1'b0) $display("FAIL b2b_abort_ovl: got %b exp 0", overload_jal); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; done_pulses = 0;
        reset = 1'b1; rha_wr_valid = 1'b0; rha_wr_data = '0;
        arm_req = 1'b0; abort_req = 1'b0;
        commit_ret_pc = 1'b0; ret_pc = '0;
        commit_ret_pc_w0 = 1'b0; ret_pc_w0 = '0;
        all_hit = 1'b0; csr_rd_addr = 2'd0;
        test_reset();
        test_basic_sequence();
        test_arm_no_rha();
        test_hit_with_all_hit();
        test_spurious();
        test_abort_and_reset();
        test_write_armed_and_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
